// File: rtl/stream_pkg.sv
// Shared definitions for the 2*DW -> DW stream splitter: output FSM encoding and default beat width.
package stream_pkg;

   localparam int DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } split_state_e;

endpackage

// File: rtl/stream_split64_if.sv
// Handshake bundle for stream_split64: 2*DW upstream word channel and DW downstream beat channel.
interface stream_split64_if
   import stream_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) ();

   logic            s_valid;
   logic            s_ready;
   logic [2*DW-1:0] s_data;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic            m_last;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/split_buf.sv
// One-entry word buffer; in_ready is a flop equal to "not full" so upstream never sees downstream timing.
module split_buf
   import stream_pkg::*;
#(
   parameter int W = 2 * DW_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         full_r;
   logic         ready_r;
   logic [W-1:0] data_r;
   logic         push_s;
   logic         pop_s;
   logic         full_next_s;

   // Occupancy update: a push only happens when empty, a pop only when full.
   always_comb begin
      push_s = in_valid && ready_r;
      pop_s  = out_ready && full_r;
      if (push_s) begin
         full_next_s = 1'b1;
      end else if (pop_s) begin
         full_next_s = 1'b0;
      end else begin
         full_next_s = full_r;
      end
   end

   // Storage and registered ready; ready stays low through reset and rises one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r  <= 1'b0;
         ready_r <= 1'b0;
         data_r  <= '0;
      end else begin
         full_r  <= full_next_s;
         ready_r <= !full_next_s;
         if (push_s) begin
            data_r <= in_data;
         end
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = full_r;
   assign out_data  = data_r;

endmodule

// File: rtl/stream_split64.sv
// Splits each 2*DW word into two DW beats (m_last on the second); STREAM_SPLIT_MSW_FIRST_EN sends the high half first.
module stream_split64
   import stream_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   stream_split64_if.slave bus
);

`ifdef STREAM_SPLIT_MSW_FIRST_EN
   localparam bit MSW_FIRST = 1'b1;
`else
   localparam bit MSW_FIRST = 1'b0;
`endif

   split_state_e    state_r;
   split_state_e    state_next_s;
   logic [DW-1:0]   half_r;
   logic [DW-1:0]   half_next_s;
   logic [DW-1:0]   m_data_r;
   logic [DW-1:0]   m_data_next_s;
   logic            m_valid_r;
   logic            m_last_r;
   logic            buf_valid_s;
   logic            buf_ready_s;
   logic            buf_in_valid_s;
   logic [2*DW-1:0] buf_data_s;
   logic [2*DW-1:0] src_s;
   logic [DW-1:0]   first_s;
   logic [DW-1:0]   second_s;
   logic            core_load_s;
   logic            direct_s;
   logic            word_avail_s;

   // Word routing: the buffer always wins over a fresh input word so order is preserved.
   always_comb begin
      core_load_s    = (state_r == ST_EMPTY) || ((state_r == ST_SECOND) && bus.m_ready);
      direct_s       = core_load_s && !buf_valid_s;
      buf_in_valid_s = bus.s_valid && !direct_s;
      word_avail_s   = buf_valid_s || (bus.s_valid && buf_ready_s);
      src_s          = buf_valid_s ? buf_data_s : bus.s_data;
      first_s        = MSW_FIRST ? src_s[2*DW-1:DW] : src_s[DW-1:0];
      second_s       = MSW_FIRST ? src_s[DW-1:0]    : src_s[2*DW-1:DW];
   end

   split_buf #(.W(2 * DW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (buf_in_valid_s),
      .in_ready  (buf_ready_s),
      .in_data   (bus.s_data),
      .out_valid (buf_valid_s),
      .out_ready (core_load_s),
      .out_data  (buf_data_s)
   );

   // Output FSM next state; the pending second half is parked in half_r.
   always_comb begin
      state_next_s  = state_r;
      half_next_s   = half_r;
      m_data_next_s = m_data_r;
      case (state_r)
         ST_EMPTY: begin
            if (word_avail_s) begin
               state_next_s  = ST_FIRST;
               m_data_next_s = first_s;
               half_next_s   = second_s;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FIRST: begin
            if (bus.m_ready) begin
               state_next_s  = ST_SECOND;
               m_data_next_s = half_r;
            end else begin
               state_next_s = ST_FIRST;
            end
         end
         ST_SECOND: begin
            if (bus.m_ready) begin
               if (word_avail_s) begin
                  state_next_s  = ST_FIRST;
                  m_data_next_s = first_s;
                  half_next_s   = second_s;
               end else begin
                  state_next_s = ST_EMPTY;
               end
            end else begin
               state_next_s = ST_SECOND;
            end
         end
         default: begin
            state_next_s = ST_EMPTY;
         end
      endcase
   end

   // State and registered beat outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_EMPTY;
         half_r    <= '0;
         m_data_r  <= '0;
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         half_r    <= half_next_s;
         m_data_r  <= m_data_next_s;
         m_valid_r <= (state_next_s != ST_EMPTY);
         m_last_r  <= (state_next_s == ST_SECOND);
      end
   end

   assign bus.s_ready = buf_ready_s;
   assign bus.m_valid = m_valid_r;
   assign bus.m_data  = m_data_r;
   assign bus.m_last  = m_last_r;

endmodule

// File: doc/stream_split64.md
STREAM_SPLIT64 -- requirements
Module: stream_split64

Interface
REQ-001 Parameter: DW, 32, output beat width; input word width is 2*DW.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: s_valid  input  1  upstream word valid.
REQ-005 Port: s_ready  output  1  upstream word accepted when s_valid and s_ready are both high at a clk edge; driven from a flop.
REQ-006 Port: s_data  input  2*DW  upstream word.
REQ-007 Port: m_valid  output  1  output beat valid.
REQ-008 Port: m_ready  input  1  beat transferred when m_valid and m_ready are both high at a clk edge.
REQ-009 Port: m_data  output  DW  output beat.
REQ-010 Port: m_last  output  1  high on the second beat of each word.

Function
REQ-011 Each accepted word SHALL produce exactly two beats, in order, with no loss or duplication.
- Default order: low half (s_data[DW-1:0]) first.
- Alternate order: see Configuration.
REQ-012 Output FSM SHALL have states EMPTY, FIRST and SECOND.
- EMPTY: m_valid=0.
- FIRST: m_valid=1, m_last=0.
- SECOND: m_valid=1, m_last=1.
REQ-013 FSM transitions SHALL be:
- FIRST to SECOND on a beat transfer.
- SECOND to FIRST on a transfer when a word is available (buffer or input).
- SECOND to EMPTY on a transfer when no word is available.
- EMPTY to FIRST when a word is available.
REQ-014 Output SHALL hold state while m_valid=1 and m_ready=0: m_data, m_last and the FSM state stay stable.
REQ-015 Latency: a word accepted at edge N into an EMPTY core SHALL present its first beat (m_valid=1) after edge N, with no combinational path from s_valid to m_valid.
REQ-016 A one-entry input buffer SHALL decouple the input; s_ready equals NOT buffer-full, registered.
REQ-017 An accepted word SHALL go directly to the core if the core loads at that edge (EMPTY, or SECOND with a transfer); otherwise it goes to the buffer.
REQ-018 The core SHALL load from the buffer before any new input word; the buffer is then freed.
REQ-019 No combinational path SHALL exist from m_ready to s_ready.
REQ-020 With s_valid and m_ready held high, m_valid SHALL stay high continuously (no bubble between words).
REQ-021 With s_valid and m_ready held high, steady-state input acceptance SHALL average one word per 2 cycles.
REQ-022 Simultaneous events: an input accept, a buffer load and an output transfer at the same edge SHALL all take effect with no word reordering.

Reset
REQ-023 While rst=1, all of the following SHALL hold: state=EMPTY, buffer empty, s_ready=0, m_valid=0, m_last=0, m_data=0.
REQ-024 s_ready SHALL rise at the first edge after rst deasserts.
REQ-025 Reset asserted mid-word SHALL discard all held data; no beat of a discarded word appears after reset.

Configuration
REQ-026 Macro STREAM_SPLIT_MSW_FIRST_EN SHALL select beat order.
- Defined: high half first, low half second (m_last on the low half).
- Undefined: low half first.
- Handshake behaviour and timing are identical in both cases.

Structure
REQ-027 Package stream_pkg SHALL hold the FSM state encoding (EMPTY/FIRST/SECOND) and a default DW constant.
REQ-028 The one-entry input buffer SHALL be a sub-module, split_buf (valid/ready in and out, width 2*DW).
REQ-029 The FSM and half-select SHALL reside in stream_split64.

Verification (DW=32, default order unless stated)
REQ-030 Single word: send 0x11223344_55667788 with m_ready=1.
- Beats 0x55667788 (m_last=0) then 0x11223344 (m_last=1) on consecutive cycles.
- m_valid=0 afterwards.
REQ-031 Back-to-back: send 8 words 0x0..0x7 (upper half = ~lower half) with m_ready=1.
- 16 beats in order with m_valid continuously high.
- s_ready duty about 50%.
REQ-032 Backpressure: m_ready=0 for 10 cycles while 3 words are offered.
- Exactly 2 words accepted (core + buffer); s_ready=0 afterwards.
- First beat held stable throughout.
- On m_ready=1, all 6 beats are delivered in order.
REQ-033 Random: s_valid and m_ready each random 50% for 1000 words.
- The scoreboard matches every beat and m_last.
- No assertion fires while s_ready=0 and s_valid=1.
REQ-034 Reset mid-word: assert rst during a SECOND beat of word 0xAAAA_BBBB.
- All outputs reach reset values immediately.
- After release, 0x1_2 yields beats 0x2 then 0x1 only.
REQ-035 With STREAM_SPLIT_MSW_FIRST_EN defined, repeat REQ-030.
- Beats 0x11223344 (m_last=0) then 0x55667788 (m_last=1).
